// File: rtl/winograd_dot_stream.sv
// Streaming Winograd inner-product unit: accumulates vectors of 2*N_PAIRS-element
// operand beats and returns either the raw pair-product sum or the true dot product.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for the first beat of a vector
// ACCUM  | accepting further beats of the current vector
// DRAIN  | input closed, waiting for the pipeline to empty
// DONE   | result presented, waiting for out_ready_i
module winograd_dot_stream #(
  parameter int IN_SIZE_0 = 8,
  parameter int IN_SIZE_1 = 8,
  parameter int N_PAIRS   = 4,
  parameter int MAX_BEATS = 16,
  localparam int MAX_W    = (IN_SIZE_0 > IN_SIZE_1) ? IN_SIZE_0 : IN_SIZE_1,
  localparam int ACC_SIZE = 2*(MAX_W+1) + $clog2(N_PAIRS) + $clog2(MAX_BEATS) + 2,
  localparam int CNT_W    = $clog2(MAX_BEATS+1)
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic                                    mode_i,
  input  logic                                    in_valid_i,
  output logic                                    in_ready_o,
  input  logic                                    in_last_i,
  input  logic [2*N_PAIRS-1:0][IN_SIZE_0-1:0]     in_0_i,
  input  logic [2*N_PAIRS-1:0][IN_SIZE_1-1:0]     in_1_i,
  output logic                                    out_valid_o,
  input  logic                                    out_ready_i,
  output logic signed [ACC_SIZE-1:0]              out_o,
  output logic [CNT_W-1:0]                        out_beats_o,
  output logic                                    out_trunc_o
);

  localparam int PRE_W  = MAX_W + 1;
  localparam int PROD_W = 2 * PRE_W;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_DONE} state_t;

  state_t                     r_state;
  logic                       r_in_ready;
  logic                       r_mode;
  logic [CNT_W-1:0]           r_cnt;
  logic                       r_trunc;
  logic                       r_out_valid;
  logic signed [ACC_SIZE-1:0] r_out;
  logic [CNT_W-1:0]           r_out_beats;
  logic                       r_out_trunc;

  logic                       r_s1_v;
  logic signed [PROD_W-1:0]   r_s1_p [N_PAIRS];
  logic signed [PROD_W-1:0]   r_s1_c [N_PAIRS];
  logic                       r_s2_v;
  logic signed [ACC_SIZE-1:0] r_s2_sum;
  logic signed [ACC_SIZE-1:0] r_acc;

  logic                       w_accept;
  logic [CNT_W-1:0]           w_cnt_nxt;
  logic                       w_hit_max;
  logic                       w_pipe_empty;
  logic signed [PRE_W-1:0]    w_pre_x [N_PAIRS];
  logic signed [PRE_W-1:0]    w_pre_y [N_PAIRS];
  logic signed [PROD_W-1:0]   w_prod  [N_PAIRS];
  logic signed [PROD_W-1:0]   w_corr  [N_PAIRS];
  logic signed [ACC_SIZE-1:0] w_sum_p;
  logic signed [ACC_SIZE-1:0] w_sum_c;
  logic signed [ACC_SIZE-1:0] w_term;

  assign w_accept     = in_valid_i & r_in_ready;
  assign w_cnt_nxt    = (r_state == S_IDLE) ? CNT_W'(1) : r_cnt + CNT_W'(1);
  assign w_hit_max    = (w_cnt_nxt == CNT_W'(MAX_BEATS));
  // The accumulate stage is fed directly by S2, so an empty S1/S2 means r_acc is final.
  assign w_pipe_empty = ~r_s1_v & ~r_s2_v;

  always_comb begin
    for (int j = 0; j < N_PAIRS; j++) begin
      w_pre_x[j] = PRE_W'($signed(in_0_i[2*j+1])) + PRE_W'($signed(in_1_i[2*j]));
      w_pre_y[j] = PRE_W'($signed(in_0_i[2*j]))   + PRE_W'($signed(in_1_i[2*j+1]));
      w_prod[j]  = PROD_W'(w_pre_x[j]) * PROD_W'(w_pre_y[j]);
      w_corr[j]  = PROD_W'($signed(in_0_i[2*j])) * PROD_W'($signed(in_0_i[2*j+1]))
                 + PROD_W'($signed(in_1_i[2*j])) * PROD_W'($signed(in_1_i[2*j+1]));
    end
  end

  always_comb begin
    w_sum_p = '0;
    w_sum_c = '0;
    for (int j = 0; j < N_PAIRS; j++) begin
      w_sum_p = w_sum_p + ACC_SIZE'(r_s1_p[j]);
      w_sum_c = w_sum_c + ACC_SIZE'(r_s1_c[j]);
    end
    w_term = r_mode ? (w_sum_p - w_sum_c) : w_sum_p;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s1_v   <= 1'b0;
      r_s2_v   <= 1'b0;
      r_s2_sum <= '0;
      r_acc    <= '0;
      for (int j = 0; j < N_PAIRS; j++) begin
        r_s1_p[j] <= '0;
        r_s1_c[j] <= '0;
      end
    end else begin
      r_s1_v <= w_accept;
      if (w_accept) begin
        for (int j = 0; j < N_PAIRS; j++) begin
          r_s1_p[j] <= w_prod[j];
          r_s1_c[j] <= w_corr[j];
        end
      end
      r_s2_v <= r_s1_v;
      if (r_s1_v) r_s2_sum <= w_term;
      // Previous vector is fully drained before IDLE, so clearing here is safe.
      if (w_accept && r_state == S_IDLE) r_acc <= '0;
      else if (r_s2_v)                   r_acc <= r_acc + r_s2_sum;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_mode      <= 1'b0;
      r_cnt       <= '0;
      r_trunc     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_out_beats <= '0;
      r_out_trunc <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_ACCUM: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_cnt <= w_cnt_nxt;
            if (r_state == S_IDLE) r_mode <= mode_i;
            if (in_last_i || w_hit_max) begin
              r_state    <= S_DRAIN;
              r_in_ready <= 1'b0;
              r_trunc    <= ~in_last_i;
            end else begin
              r_state <= S_ACCUM;
            end
          end
        end
        S_DRAIN: begin
          r_in_ready <= 1'b0;
          if (w_pipe_empty) begin
            r_out       <= r_acc;
            r_out_beats <= r_cnt;
            r_out_trunc <= r_trunc;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready_i) begin
            r_out_valid <= 1'b0;
            r_out_trunc <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready_o  = r_in_ready;
  assign out_valid_o = r_out_valid;
  assign out_o       = r_out;
  assign out_beats_o = r_out_beats;
  assign out_trunc_o = r_out_trunc;

endmodule

// File: doc/winograd_dot_stream.md
Name: winograd_dot_stream

Overview:
- Streaming, parametrised successor of the fixed 8-element Winograd inner-product unit.
- Accepts beats of 2*N_PAIRS signed operand pairs over a valid/ready interface and accumulates a vector of up to MAX_BEATS beats.
- Returns one scalar per vector, either the raw Winograd pair-product sum (mode 0) or the corrected true dot product (mode 1).
- Sits between the operand-fetch stage and the output writeback of the AI core datapath.

Parameters:
- IN_SIZE_0, 8, signed width of each in_0 element (operand A).
- IN_SIZE_1, 8, signed width of each in_1 element (operand B).
- N_PAIRS, 4, element pairs per beat; 2*N_PAIRS elements per operand per beat; power of two, ≥1.
- MAX_BEATS, 16, maximum beats per vector before forced termination; power of two, ≥2.
- ACC_SIZE (localparam), 2*(max(IN_SIZE_0,IN_SIZE_1)+1) + $clog2(N_PAIRS) + $clog2(MAX_BEATS) + 2, result width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous, active-low reset.
- mode_i  in  1  0 = raw Winograd sum, 1 = corrected dot product; sampled on the first beat of each vector.
- in_valid_i  in  1  beat valid.
- in_ready_o  out  1  beat ready.
- in_last_i  in  1  marks the final beat of a vector.
- in_0_i  in  [2*N_PAIRS][IN_SIZE_0] packed  operand A elements.
- in_1_i  in  [2*N_PAIRS][IN_SIZE_1] packed  operand B elements.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  result ready.
- out_o  out  ACC_SIZE  signed result.
- out_beats_o  out  $clog2(MAX_BEATS+1)  number of beats accumulated into out_o.
- out_trunc_o  out  1  vector was force-terminated at MAX_BEATS without in_last_i.

Behaviour:
- Reset (asynchronous, active-low): FSM=IDLE; pipeline valids, accumulator, beat counter and mode latch cleared; out_valid_o=0, out_o=0, out_beats_o=0, out_trunc_o=0, in_ready_o=0 while rst_ni low.
- Any in-flight vector is discarded on reset; no partial result is emitted.
- A beat transfers when in_valid_i & in_ready_o on a rising clk_i edge.
- Per-beat math, signed, all terms sign-extended to ACC_SIZE, for j = 0..N_PAIRS-1:
  - P_j = (a[2j+1]+b[2j])*(a[2j]+b[2j+1]).
  - C_j = a[2j]*a[2j+1] + b[2j]*b[2j+1].
  - Beat term = ΣP_j (mode 0) or ΣP_j − ΣC_j (mode 1).
- The accumulator wraps modulo 2^ACC_SIZE (two's complement); no saturation.
- Pipeline:
  - S1 registers pre-adds and products.
  - S2 registers the adder-tree sum.
  - The accumulate stage adds into the accumulator.
  - Each stage carries a valid bit; input bubbles are allowed.
- FSM:
  - IDLE: in_ready_o=1. First accepted beat latches mode_i, clears the accumulator and sets the beat count to 1. If in_last_i=1 or MAX_BEATS reached → DRAIN, else → ACCUM.
  - ACCUM: in_ready_o=1. Each accepted beat increments the count. On in_last_i=1 → DRAIN. If the count reaches MAX_BEATS without last → DRAIN with trunc flag set. mode_i is ignored after the first beat.
  - DRAIN: in_ready_o=0. Waits until the S1, S2 and accumulate valids are all clear, then loads out_o, out_beats_o, out_trunc_o → DONE.
  - DONE: out_valid_o=1; out_o, out_beats_o and out_trunc_o are held stable. On out_ready_i=1 → IDLE, clearing out_valid_o and out_trunc_o on that edge. in_ready_o=0 in DONE.
- Latency: out_valid_o rises exactly 3 clk_i edges after the edge accepting the final beat.
- A single-beat vector behaves identically (first beat = last beat).
- out_ready_i may be high before out_valid_o; the handshake completes on the first DONE cycle.
- A beat presented during DRAIN or DONE is held by the source and accepted in the next IDLE cycle.
- in_last_i on the beat that also reaches MAX_BEATS: the vector ends normally and out_trunc_o=0.

Test Plan:
- Single beat, all a=1, all b=1, last=1, mode 1 → out_o=8, out_beats_o=1, out_valid_o high 3 edges after acceptance; same stimulus with mode 0 → out_o=16.
- 16 beats, a=127, b=−128, last on beat 16, mode 1 → out_o=−2080768, out_beats_o=16, out_trunc_o=0; same with mode 0 → out_o=64.
- 17 beats, no last, a=1, b=1, mode 1:
  - After beat 16 → out_o=128, out_beats_o=16, out_trunc_o=1.
  - Beat 17 is held (in_ready_o=0) until DONE completes, then starts a new vector.
- Backpressure: out_ready_i low 5 cycles after out_valid_o → out_o, out_beats_o and out_valid_o stable, in_ready_o=0; out_ready_i high → IDLE next cycle, in_ready_o=1.
- Bubbles: 4 beats of a=2, b=−3 with in_valid_i low 2 cycles between beats, mode 1 → out_o=4*8*(−6)=−192, out_beats_o=4.
- Reset: rst_ni low for 1 cycle after 3 accepted beats → all outputs 0 immediately. Next single beat of all 1s, mode 1 → out_o=8, with no contribution from the aborted vector.
- Random: 200 vectors, random lengths 1..16, random mode and random stall patterns → each result equals a golden model modulo 2^ACC_SIZE.
